// File: rtl/ps2_cmd_scheduler.sv
// Schedules the single PS/2 host-to-keyboard transmitter between power-up init, CPU SCANCODE
// writes and LED updates, handling ACK/RESEND, timeouts and retries per byte.
module ps2_cmd_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 560000,
  parameter int unsigned BAT_CYCLES     = 28000000,
  parameter int unsigned RETRIES        = 2,
  parameter bit          POWERUP_INIT   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cpu_data,
  input  logic       cpu_load,
  input  logic [2:0] led_state,
  output logic [7:0] tx_data,
  output logic       tx_load,
  input  logic       tx_busy,
  input  logic       tx_error,
  input  logic       rx_valid,
  input  logic [7:0] rx_code,
  output logic       rx_swallow,
  output logic       cpu_busy,
  output logic       ack_err,
  output logic       init_done
);

  localparam int unsigned MaxCycles = (TIMEOUT_CYCLES > BAT_CYCLES) ? TIMEOUT_CYCLES : BAT_CYCLES;
  localparam int unsigned TimerW    = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;
  localparam int unsigned AttW      = ($clog2(RETRIES + 1) > 2) ? $clog2(RETRIES + 1) : 2;

  localparam logic [TimerW-1:0] TxLimit  = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] BatLimit = TimerW'(BAT_CYCLES - 1);
  localparam logic [AttW-1:0]   MaxRetry = AttW'(RETRIES);

  localparam logic [7:0] CmdReset   = 8'hFF;
  localparam logic [7:0] CmdLed     = 8'hED;
  localparam logic [7:0] CodeAck    = 8'hFA;
  localparam logic [7:0] CodeResend = 8'hFE;
  localparam logic [7:0] CodeBatOk  = 8'hAA;
  localparam logic [7:0] CodeBatErr = 8'hFC;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitTx,
    StWaitAck,
    StWaitBat,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    SeqInit,
    SeqCpu,
    SeqLed
  } seq_e;

  state_e            state_q, state_d;
  seq_e              seq_q;
  logic [1:0]        step_q;
  logic [AttW-1:0]   attempts_q;
  logic [TimerW-1:0] timer_q;
  logic              busy_seen_q;
  logic [7:0]        tx_data_q;
  logic              tx_load_q;
  logic              init_pend_q;
  logic              init_done_q;
  logic              cpu_pend_q;
  logic              cpu_run_q;
  logic [7:0]        cpu_byte_q;
  logic [7:0]        act_byte_q;
  logic              led_pend_q;
  logic [2:0]        led_shadow_q;
  logic              ack_err_q;

  logic       start_init, start_cpu, start_led;
  logic       load_fire, byte_ok, bat_ok, att_fail, abort;
  logic [7:0] byte_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_init = 1'b0;
    start_cpu  = 1'b0;
    start_led  = 1'b0;
    load_fire  = 1'b0;
    byte_ok    = 1'b0;
    bat_ok     = 1'b0;
    att_fail   = 1'b0;
    abort      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (init_pend_q) begin
          start_init = 1'b1;
          state_d    = StLoad;
        end else if (cpu_pend_q) begin
          start_cpu = 1'b1;
          state_d   = StLoad;
        end else if (led_pend_q) begin
          start_led = 1'b1;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        if (!tx_busy) begin
          load_fire = 1'b1;
          state_d   = StWaitTx;
        end
      end
      StWaitTx: begin
        if (busy_seen_q && !tx_busy) begin
          if (tx_error) begin
            att_fail = 1'b1;
          end else begin
            state_d = StWaitAck;
          end
        end else if (timer_q >= TxLimit) begin
          att_fail = 1'b1;
        end
      end
      StWaitAck: begin
        if (rx_valid && rx_code == CodeAck) begin
          byte_ok = 1'b1;
          if (seq_q == SeqInit && step_q == 2'd0) begin
            state_d = StWaitBat;
          end else if (seq_q == SeqCpu || step_q == 2'd2) begin
            state_d = StDone;
          end else begin
            state_d = StLoad;
          end
        end else if (rx_valid && rx_code == CodeResend) begin
          att_fail = 1'b1;
        end else if (timer_q >= TxLimit) begin
          att_fail = 1'b1;
        end
      end
      StWaitBat: begin
        if (rx_valid && rx_code == CodeBatOk) begin
          bat_ok  = 1'b1;
          state_d = StLoad;
        end else if ((rx_valid && rx_code == CodeBatErr) || timer_q >= BatLimit) begin
          abort   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Retry the same byte while attempts remain, otherwise abandon the sequence.
    if (att_fail) begin
      if (attempts_q < MaxRetry) begin
        state_d = StLoad;
      end else begin
        abort   = 1'b1;
        state_d = StDone;
      end
    end
  end

  always_comb begin
    byte_sel = 8'h00;
    if (seq_q == SeqCpu) begin
      byte_sel = act_byte_q;
    end else if (step_q == 2'd0) begin
      byte_sel = CmdReset;
    end else if (step_q == 2'd1) begin
      byte_sel = CmdLed;
    end else begin
      byte_sel = {5'b00000, led_state};
    end
    rx_swallow = rx_valid &
                 (((state_q == StWaitAck) & ((rx_code == CodeAck) | (rx_code == CodeResend))) |
                  ((state_q == StWaitBat) & ((rx_code == CodeBatOk) | (rx_code == CodeBatErr))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q        <= SeqInit;
      step_q       <= 2'd0;
      attempts_q   <= '0;
      timer_q      <= '0;
      busy_seen_q  <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_load_q    <= 1'b0;
      init_pend_q  <= POWERUP_INIT;
      init_done_q  <= !POWERUP_INIT;
      cpu_pend_q   <= 1'b0;
      cpu_run_q    <= 1'b0;
      cpu_byte_q   <= 8'h00;
      act_byte_q   <= 8'h00;
      led_pend_q   <= 1'b0;
      led_shadow_q <= led_state;
      ack_err_q    <= 1'b0;
    end else begin
      tx_load_q <= load_fire;
      if (load_fire) begin
        tx_data_q <= byte_sel;
        if (seq_q != SeqCpu && step_q == 2'd2) begin
          led_shadow_q <= led_state;
        end
      end

      // Any state change restarts the timer; it saturates rather than wrapping.
      if (state_d != state_q) begin
        timer_q <= '0;
      end else if (timer_q != '1) begin
        timer_q <= timer_q + 1'b1;
      end
      busy_seen_q <= (state_q == StWaitTx) && (busy_seen_q || tx_busy);

      if (start_init || start_cpu || start_led) begin
        attempts_q <= '0;
      end
      if (start_init) begin
        seq_q  <= SeqInit;
        step_q <= 2'd0;
      end
      if (start_cpu) begin
        seq_q      <= SeqCpu;
        step_q     <= 2'd0;
        act_byte_q <= cpu_byte_q;
        cpu_run_q  <= 1'b1;
        cpu_pend_q <= 1'b0;
      end
      if (start_led) begin
        seq_q  <= SeqLed;
        step_q <= 2'd1;
      end
      if (byte_ok) begin
        attempts_q <= '0;
        step_q     <= step_q + 2'd1;
      end
      if (att_fail && attempts_q < MaxRetry) begin
        attempts_q <= attempts_q + 1'b1;
      end

      if (state_q == StDone) begin
        if (seq_q == SeqInit) begin
          init_pend_q <= 1'b0;
          init_done_q <= 1'b1;
        end
        if (seq_q == SeqCpu) begin
          cpu_run_q <= 1'b0;
        end
      end

      // A write after the current byte started becomes the next pending request.
      if (cpu_load) begin
        cpu_byte_q <= cpu_data;
        cpu_pend_q <= 1'b1;
      end

      if (led_state != led_shadow_q) begin
        led_pend_q <= 1'b1;
      end else if (state_q == StDone && seq_q != SeqCpu) begin
        led_pend_q <= 1'b0;
      end

      if (abort) begin
        ack_err_q <= 1'b1;
      end else if (cpu_load) begin
        ack_err_q <= 1'b0;
      end
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_load   = tx_load_q;
  assign cpu_busy  = cpu_pend_q | cpu_run_q;
  assign ack_err   = ack_err_q;
  assign init_done = init_done_q;

  logic unused_bat_ok;
  assign unused_bat_ok = bat_ok;

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Bench for ps2_cmd_scheduler: scripted keyboard/transmitter model with random CPU traffic,
// checked against a transaction-level model of the retry rules.
module tb_ps2_cmd_scheduler;

  localparam int unsigned To  = 200;
  localparam int unsigned Bat = 600;
  localparam int unsigned Ret = 2;

  logic       clk;
  logic       rst;
  logic [7:0] cpu_data;
  logic       cpu_load;
  logic [2:0] led_state;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_busy;
  logic       tx_error;
  logic       rx_valid;
  logic [7:0] rx_code;
  logic       rx_swallow;
  logic       cpu_busy;
  logic       ack_err;
  logic       init_done;

  logic model_busy;
  logic force_busy;
  assign tx_busy = model_busy | force_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  logic [7:0]  cap_q[$];
  int          cap_t[$];
  // Reply script, one entry per transmission: low byte first, high byte next (0 = none).
  // 16'h0000 = keyboard silent, 16'h0001 = transmitter reports an error.
  logic [15:0] reply_q[$];
  logic        kb_idle;

  ps2_cmd_scheduler #(
    .TIMEOUT_CYCLES(To),
    .BAT_CYCLES    (Bat),
    .RETRIES       (Ret),
    .POWERUP_INIT  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_data  (cpu_data),
    .cpu_load  (cpu_load),
    .led_state (led_state),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_busy   (tx_busy),
    .tx_error  (tx_error),
    .rx_valid  (rx_valid),
    .rx_code   (rx_code),
    .rx_swallow(rx_swallow),
    .cpu_busy  (cpu_busy),
    .ack_err   (ack_err),
    .init_done (init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_swallow(input logic [7:0] c);
    return (c == 8'hFA) || (c == 8'hFE) || (c == 8'hAA) || (c == 8'hFC);
  endfunction

  task automatic send_rx(input logic [7:0] code, input logic exp_sw);
    @(negedge clk);
    rx_code  = code;
    rx_valid = 1'b1;
    #2;
    check($sformatf("swallow_%02h", code), 32'(rx_swallow), 32'(exp_sw));
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Transmitter and keyboard model.
  initial begin
    model_busy = 1'b0;
    tx_error   = 1'b0;
    rx_valid   = 1'b0;
    rx_code    = 8'h00;
    kb_idle    = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_load === 1'b1) begin : xfer
        logic [15:0] e;
        kb_idle = 1'b0;
        cap_q.push_back(tx_data);
        cap_t.push_back(cycle);
        e = (reply_q.size() > 0) ? reply_q.pop_front() : 16'h0000;
        model_busy = 1'b1;
        repeat ($urandom_range(3, 10)) @(negedge clk);
        model_busy = 1'b0;
        tx_error   = (e == 16'h0001);
        @(negedge clk);
        tx_error = 1'b0;
        if (e[7:0] > 8'h01) begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          send_rx(e[7:0], exp_swallow(e[7:0]));
          if (e[15:8] != 8'h00) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            send_rx(e[15:8], exp_swallow(e[15:8]));
          end
        end
        kb_idle = 1'b1;
      end
    end
  end

  task automatic wait_init(input string tag);
    for (int i = 0; i < 4000 && !init_done; i++) @(negedge clk);
    check(tag, 32'(init_done), 32'd1);
    for (int i = 0; i < 100 && !kb_idle; i++) @(negedge clk);
    repeat (20) @(negedge clk);
  endtask

  task automatic run_cpu(input logic [7:0] b, input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input bit check_gap);
    logic [15:0] ents[3];
    int          n;
    bit          ok;
    ents = '{e0, e1, e2};
    // A byte is sent until acknowledged, at most RETRIES+1 times.
    n  = 0;
    ok = 1'b0;
    for (int a = 0; a <= int'(Ret) && !ok; a++) begin
      n++;
      if (ents[a] == 16'h00FA || ents[a] == 16'hFA1C) ok = 1'b1;
    end
    cap_q.delete();
    cap_t.delete();
    reply_q.delete();
    for (int a = 0; a < 3; a++) reply_q.push_back(ents[a]);
    @(negedge clk);
    cpu_data = b;
    cpu_load = 1'b1;
    @(negedge clk);
    cpu_load = 1'b0;
    check("cpu_busy_set", 32'(cpu_busy), 32'd1);
    check("ack_err_clr", 32'(ack_err), 32'd0);
    for (int i = 0; i < 4 * (int'(To) + 50) && cpu_busy; i++) @(negedge clk);
    check("cpu_busy_clr", 32'(cpu_busy), 32'd0);
    for (int i = 0; i < 50 && !kb_idle; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("tx_count", 32'(cap_q.size()), 32'(n));
    for (int i = 0; i < cap_q.size(); i++) check("tx_byte", 32'(cap_q[i]), 32'(b));
    check("ack_err", 32'(ack_err), 32'(!ok));
    if (check_gap) begin
      for (int i = 1; i < cap_t.size(); i++) begin
        check("retry_gap", 32'((cap_t[i] - cap_t[i-1] >= int'(To)) &&
                               (cap_t[i] - cap_t[i-1] <= int'(To) + 20)), 32'd1);
      end
    end
  endtask

  initial begin
    int          lat;
    logic [15:0] pick[5];
    pick = '{16'h00FA, 16'h00FE, 16'h0000, 16'h0001, 16'hFA1C};
    rst        = 1'b1;
    cpu_data   = 8'h00;
    cpu_load   = 1'b0;
    led_state  = 3'b000;
    force_busy = 1'b0;

    // Power-up init: FF (FA, AA), ED (FA), 00 (FA).
    reply_q.push_back(16'hAAFA);
    reply_q.push_back(16'h00FA);
    reply_q.push_back(16'h00FA);
    repeat (3) @(negedge clk);
    check("rst_tx_load", 32'(tx_load), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_cpu_busy", 32'(cpu_busy), 32'd0);
    check("rst_ack_err", 32'(ack_err), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (tx_load && lat == 0) lat = i + 1;
    end
    check("init_start_latency", 32'(lat >= 1 && lat <= 3), 32'd1);
    wait_init("init_done");
    check("init_ack_err", 32'(ack_err), 32'd0);
    check("init_count", 32'(cap_q.size()), 32'd3);
    check("init_b0", 32'(cap_q[0]), 32'hFF);
    check("init_b1", 32'(cap_q[1]), 32'hED);
    check("init_b2", 32'(cap_q[2]), 32'h00);

    // Directed CPU cases.
    run_cpu(8'hF3, 16'h00FA, 16'h0000, 16'h0000, 1'b0);
    send_rx(8'h1C, 1'b0);
    run_cpu(8'hF4, 16'h00FE, 16'h00FE, 16'h00FA, 1'b0);
    run_cpu(8'hF5, 16'h0000, 16'h0000, 16'h0000, 1'b1);

    // Random CPU traffic.
    for (int t = 0; t < 8; t++) begin
      run_cpu(8'($urandom), pick[$urandom_range(0, 4)], pick[$urandom_range(0, 4)],
              pick[$urandom_range(0, 4)], 1'b0);
    end

    // LED changes during a CPU sequence are coalesced into one LED update afterwards.
    cap_q.delete();
    reply_q.delete();
    for (int a = 0; a < 3; a++) reply_q.push_back(16'h00FA);
    @(negedge clk);
    cpu_data = 8'hEE;
    cpu_load = 1'b1;
    @(negedge clk);
    cpu_load = 1'b0;
    for (int i = 0; i < 100 && cap_q.size() == 0; i++) @(negedge clk);
    led_state = 3'b100;
    repeat (3) @(negedge clk);
    led_state = 3'b110;
    for (int i = 0; i < 600 && cpu_busy; i++) @(negedge clk);
    for (int i = 0; i < 600 && !(cap_q.size() >= 3 && kb_idle); i++) @(negedge clk);
    repeat (60) @(negedge clk);
    check("led_count", 32'(cap_q.size()), 32'd3);
    check("led_b0", 32'(cap_q[0]), 32'hEE);
    check("led_b1", 32'(cap_q[1]), 32'hED);
    check("led_b2", 32'(cap_q[2]), 32'h06);

    // Reset while waiting for an ACK with the transmitter still busy.
    cap_q.delete();
    reply_q.delete();
    reply_q.push_back(16'h0000);
    @(negedge clk);
    cpu_data = 8'hF2;
    cpu_load = 1'b1;
    @(negedge clk);
    cpu_load = 1'b0;
    for (int i = 0; i < 100 && !(cap_q.size() == 1 && kb_idle); i++) @(negedge clk);
    reply_q.push_back(16'hAAFA);
    reply_q.push_back(16'h00FA);
    reply_q.push_back(16'h00FA);
    force_busy = 1'b1;
    rst        = 1'b1;
    @(negedge clk);
    check("mid_rst_tx_load", 32'(tx_load), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_cpu_busy", 32'(cpu_busy), 32'd0);
    check("mid_rst_ack_err", 32'(ack_err), 32'd0);
    check("mid_rst_init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cap_q.delete();
    cap_t.delete();
    repeat (20) @(negedge clk);
    check("held_by_busy", 32'(cap_q.size()), 32'd0);
    lat        = cycle;
    force_busy = 1'b0;
    wait_init("reinit_done");
    check("reinit_count", 32'(cap_q.size()), 32'd3);
    check("reinit_b0", 32'(cap_q[0]), 32'hFF);
    check("reinit_b1", 32'(cap_q[1]), 32'hED);
    check("reinit_b2", 32'(cap_q[2]), 32'h06);
    check("reinit_after_busy", 32'(cap_t.size() > 0 && cap_t[0] >= lat), 32'd1);

    // Self-test failure code during init aborts it.
    cap_q.delete();
    reply_q.delete();
    reply_q.push_back(16'hFCFA);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_init("batfail_done");
    check("batfail_count", 32'(cap_q.size()), 32'd1);
    check("batfail_b0", 32'(cap_q[0]), 32'hFF);
    check("batfail_ack_err", 32'(ack_err), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_scheduler.md
Name: ps2_cmd_scheduler

Overview:
- Sequences and arbitrates the single PS/2 host-to-keyboard transmitter among three requesters:
  - power-up keyboard init;
  - CPU writes to the SCANCODE register;
  - automatic LED updates.
- Sits between the register decode and the host-to-keyboard transmitter, and snoops the keyboard receive port.
- Handles per byte: ACK (0xFA), RESEND (0xFE), timeouts and retries.
- Swallows protocol replies so the keymap translator never sees them.

Parameters:
- TIMEOUT_CYCLES, 560000, max clk cycles spent in WAIT_TX or WAIT_ACK per attempt (20 ms at 28 MHz).
- BAT_CYCLES, 28000000, max cycles to wait for 0xAA after reset ACK (1 s).
- RETRIES, 2, extra transmissions per byte after the first attempt fails.
- POWERUP_INIT, 1, if 1 run the init sequence after rst.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_data  in  8  byte written to SCANCODE
- cpu_load  in  1  one-cycle strobe, SCANCODE write
- led_state  in  3  {caps, num, scroll}
- tx_data  out  8  byte to transmitter
- tx_load  out  1  one-cycle load strobe to transmitter
- tx_busy  in  1  transmitter busy
- tx_error  in  1  transmitter error, sampled when busy falls
- rx_valid  in  1  new received byte strobe
- rx_code  in  8  received byte
- rx_swallow  out  1  combinational: rx byte consumed here, downstream must ignore it
- cpu_busy  out  1  CPU request pending or in progress
- ack_err  out  1  sticky: last sequence aborted
- init_done  out  1  init sequence finished (pass or fail)

Behaviour:
- Reset values: tx_load=0, tx_data=0, cpu_busy=0, ack_err=0, init_done=0 (1 if POWERUP_INIT=0), state=IDLE, all pending flags cleared, led_shadow=led_state.
- States: IDLE, LOAD, WAIT_TX, WAIT_ACK, WAIT_BAT, DONE.
- Sequences:
  - INIT: 0xFF, then wait for 0xAA, then LED sequence.
  - CPU: single byte cpu_data.
  - LED: 0xED, then {5'b0, caps, num, scroll}.
- Arbitration in IDLE only: INIT > CPU > LED. INIT starts one cycle after rst deasserts.
- CPU request buffer is one deep:
  - cpu_load latches cpu_data and sets cpu_pend.
  - A cpu_load while cpu_pend=1 and the byte is not yet started overwrites the latched byte.
  - A cpu_load after the byte has started sets a second pend, served next.
  - cpu_busy=1 from the cycle after cpu_load until the CPU sequence reaches DONE.
  - A cpu_load also clears ack_err.
- LED request:
  - led_pend is set whenever led_state differs from led_shadow.
  - led_shadow is updated when the LED data byte is loaded.
  - A change during the sequence re-sets led_pend, so the sequence reruns afterwards; changes are coalesced.
- Per-byte attempt loop:
  - LOAD: wait for tx_busy=0, then drive tx_data and pulse tx_load for 1 cycle, clear the timer, enter WAIT_TX.
  - WAIT_TX: wait for tx_busy rise then fall.
    - If tx_error=1 at the fall: attempt failed.
    - Otherwise enter WAIT_ACK with the timer cleared.
  - WAIT_ACK:
    - rx 0xFA: byte OK. Go to the next byte, to WAIT_BAT after 0xFF, or to DONE.
    - rx 0xFE: attempt failed.
    - Other bytes are passed through, not swallowed.
  - Timer reaching TIMEOUT_CYCLES in WAIT_TX or WAIT_ACK: attempt failed.
  - Attempt failed: if attempts used < RETRIES+1, go to LOAD with the same byte. Otherwise set ack_err, abort the rest of the sequence, go to DONE.
- WAIT_BAT:
  - rx 0xAA continues.
  - rx 0xFC, or BAT_CYCLES timeout, sets ack_err and aborts.
- rx_swallow = rx_valid & ((WAIT_ACK & rx_code in {FA,FE}) | (WAIT_BAT & rx_code in {AA,FC})).
- DONE:
  - 1 cycle; clears the finished pend flag.
  - Sets init_done if the sequence was INIT.
  - Returns to IDLE.
- Bytes start back-to-back: the next tx_load occurs 2 cycles after the ACK byte, once tx_busy=0.
- rst mid-operation: everything returns to reset values next cycle. The transmitter is not aborted; LOAD waits for tx_busy=0.
- The attempt counter is 2 bits minimum. Timer width is clog2 of max(TIMEOUT_CYCLES, BAT_CYCLES); it saturates and never wraps.

Test Plan:
- rst released, keyboard replies FA then AA, then FA, FA → tx bytes FF, ED, 00 in order; init_done=1; ack_err=0; all four rx bytes swallowed.
- After init, cpu_load with 0xF3, keyboard replies FA → one tx_load with tx_data=F3; cpu_busy high until DONE then 0; rx FA swallowed, and a following rx 0x1C is not swallowed.
- CPU byte 0xF4, replies FE, FE, FA → three tx_load pulses, all 0xF4; ack_err=0.
- CPU byte with no reply → 3 attempts, each TIMEOUT_CYCLES apart; ack_err=1; next cpu_load clears ack_err.
- led_state changes 000→100 during a CPU sequence, then 100→110 before it is served → one LED sequence only, after the CPU byte, sending ED, 06.
- rst asserted while in WAIT_ACK with tx_busy=1 → outputs at reset values next cycle; init re-runs, and its first tx_load occurs only after tx_busy falls.
